// File: rtl/fifo_vc_router_pkg.sv
// Shared constants and occupancy encoding for the FIFO-to-virtual-channel router.
// Occupancy helpers saturate at the ends of the 0..2 range.
package fifo_vc_router_pkg;

    localparam int DATA_WIDTH = 10;
    localparam int CLASS_BIT  = 9;
    localparam int CNT_WIDTH  = 8;

    localparam logic VC0 = 1'b0;
    localparam logic VC1 = 1'b1;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } occ_e;

    function automatic occ_e occ_inc(input occ_e o);
        return (o == EMPTY) ? ONE : FULL;
    endfunction

    function automatic occ_e occ_dec(input occ_e o);
        return (o == FULL) ? ONE : EMPTY;
    endfunction

endpackage

// File: rtl/fifo_vc_router_if.sv
// Handshake bundle between the router, the upstream transaction FIFO and the two VC FIFOs.
// master = router side, slave = surrounding FIFOs / environment.
interface fifo_vc_router_if;
    import fifo_vc_router_pkg::*;

    logic                  enable;
    logic                  fifo_empty;
    logic [DATA_WIDTH-1:0] fifo_data;
    logic                  fifo_pop;
    logic                  vc0_almost_full;
    logic                  vc1_almost_full;
    logic [DATA_WIDTH-1:0] vc_data;
    logic                  vc0_push;
    logic                  vc1_push;
    logic [CNT_WIDTH-1:0]  vc0_count;
    logic [CNT_WIDTH-1:0]  vc1_count;
    logic                  idle;

    modport master (
        input  enable, fifo_empty, fifo_data, vc0_almost_full, vc1_almost_full,
        output fifo_pop, vc_data, vc0_push, vc1_push, vc0_count, vc1_count, idle
    );

    modport slave (
        output enable, fifo_empty, fifo_data, vc0_almost_full, vc1_almost_full,
        input  fifo_pop, vc_data, vc0_push, vc1_push, vc0_count, vc1_count, idle
    );

endinterface

// File: rtl/fifo_vc_router_route_skid_buf.sv
// Two-entry in-order queue holding words fetched from the upstream FIFO.
// Only the head is visible; the caller guarantees no write when full and no read when empty.
module route_skid_buf
    import fifo_vc_router_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    input  logic                  rd_en_i,
    output logic [DATA_WIDTH-1:0] head_o,
    output occ_e                  count_o
);

    logic [DATA_WIDTH-1:0] mem_q [2];
    logic                  wr_ptr_q;
    logic                  rd_ptr_q;
    occ_e                  count_q;
    occ_e                  count_d;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        count_d = count_q;
        case ({wr_en_i, rd_en_i})
            2'b10:   count_d = occ_inc(count_q);
            2'b01:   count_d = occ_dec(count_q);
            default: count_d = count_q;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= EMPTY;
        end else begin
            if (wr_en_i) wr_ptr_q <= ~wr_ptr_q;
            if (rd_en_i) rd_ptr_q <= ~rd_ptr_q;
            count_q <= count_d;
        end
    end

    // NOTE: storage is left unreset; it is never observed while count_q says the entry is empty.
    always_ff @(posedge clk) begin
        if (wr_en_i) mem_q[wr_ptr_q] <= wr_data_i;
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/fifo_vc_router.sv
// Pops the shared transaction FIFO and steers each word, in order, to VC0 or VC1 by its class bit.
// Occupancy FSM counts buffered words plus the fetch whose data arrives next cycle.
module fifo_vc_router
    import fifo_vc_router_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    fifo_vc_router_if.master bus
);

    occ_e                  occ_q;
    occ_e                  occ_d;
    logic                  pending_q;
    logic [CNT_WIDTH-1:0]  cnt0_q;
    logic [CNT_WIDTH-1:0]  cnt1_q;
    logic [DATA_WIDTH-1:0] head;
    occ_e                  buf_count;
    logic                  head_valid;
    logic                  push0;
    logic                  push1;
    logic                  leaving;
    logic                  pop;

    route_skid_buf u_buf (
        .clk       (clk),
        .reset     (reset),
        .wr_en_i   (pending_q),
        .wr_data_i (bus.fifo_data),
        .rd_en_i   (leaving),
        .head_o    (head),
        .count_o   (buf_count)
    );

    always_comb begin
        head_valid = (buf_count != EMPTY);
        push0      = head_valid && (head[CLASS_BIT] == VC0) && !bus.vc0_almost_full;
        push1      = head_valid && (head[CLASS_BIT] == VC1) && !bus.vc1_almost_full;
        leaving    = push0 || push1;
        // Reset gates the pop so no fetch is issued while state is being cleared.
        pop        = !reset && bus.enable && !bus.fifo_empty && ((occ_q != FULL) || leaving);

        occ_d = occ_q;
        case ({pop, leaving})
            2'b10:   occ_d = occ_inc(occ_q);
            2'b01:   occ_d = occ_dec(occ_q);
            default: occ_d = occ_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            occ_q     <= EMPTY;
            pending_q <= 1'b0;
            cnt0_q    <= '0;
            cnt1_q    <= '0;
        end else begin
            occ_q     <= occ_d;
            pending_q <= pop;
            if (push0) cnt0_q <= cnt0_q + CNT_WIDTH'(1);
            if (push1) cnt1_q <= cnt1_q + CNT_WIDTH'(1);
        end
    end

    assign bus.fifo_pop  = pop;
    assign bus.vc0_push  = push0;
    assign bus.vc1_push  = push1;
    assign bus.vc_data   = head_valid ? head : '0;
    assign bus.vc0_count = cnt0_q;
    assign bus.vc1_count = cnt1_q;
    assign bus.idle      = (occ_q == EMPTY);

endmodule
